// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter and its burst counter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    localparam int defVecSize  = 4;
    localparam int defDataSize = 8;

    typedef logic [defVecSize-1:0][defDataSize-1:0] beat_t;

    // Width of a burst length field able to hold 0..maxBurst.
    function automatic int lenW(input int maxBurst);
        return $clog2(maxBurst + 1);
    endfunction

endpackage

// File: rtl/dmem_burst_counter.sv
// Holds the accepted host burst (base, length, direction) and generates the beat address
// for the current beat; flags the final beat of the burst.
module dmem_burst_counter
    import dmem_arb_pkg::*;
#(
    parameter int vecSize  = 4,
    parameter int regSize  = 16,
    parameter int maxBurst = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        advance,
    input  logic                        we,
    input  logic [regSize-1:0]          base,
    input  logic [lenW(maxBurst)-1:0]   len,
    output logic                        burstWe,
    output logic [regSize-1:0]          beatAddr,
    output logic                        lastBeat,
    output logic                        lenZero
);

    localparam int lenBits = lenW(maxBurst);

    logic [lenBits-1:0] clampedLen;
    logic [lenBits-1:0] burstLen;
    logic [lenBits-1:0] beatCnt;
    logic [regSize-1:0] burstBase;

    assign clampedLen = (len > lenBits'(maxBurst)) ? lenBits'(maxBurst) : len;
    assign lenZero    = (clampedLen == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burstBase <= '0;
            burstLen  <= '0;
            burstWe   <= 1'b0;
            beatCnt   <= '0;
        end else if (load) begin
            burstBase <= base;
            burstLen  <= clampedLen;
            burstWe   <= we;
            beatCnt   <= '0;
        end else if (advance) begin
            beatCnt   <= beatCnt + lenBits'(1);
        end
    end

    // Address arithmetic wraps modulo 2^regSize by truncation.
    assign beatAddr = burstBase + regSize'(beatCnt) * regSize'(vecSize);
    assign lastBeat = ((beatCnt + lenBits'(1)) == burstLen);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the pipeline (per-cycle priority) and a
// host burst loader protected by a bounded starvation guard.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int vecSize     = 4,
    parameter int regSize     = 16,
    parameter int dataSize    = 8,
    parameter int maxBurst    = 16,
    parameter int starveLimit = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pipe_req,
    input  logic                          pipe_we,
    input  logic [regSize-1:0]            pipe_addr,
    input  logic [vecSize*dataSize-1:0]   pipe_wdata,
    output logic                          pipe_stall,
    output logic                          pipe_rvalid,
    output logic [vecSize*dataSize-1:0]   pipe_rdata,
    input  logic                          host_req,
    input  logic                          host_we,
    input  logic [regSize-1:0]            host_base,
    input  logic [lenW(maxBurst)-1:0]     host_len,
    input  logic [vecSize*dataSize-1:0]   host_wdata,
    output logic                          host_busy,
    output logic                          host_beat,
    output logic                          host_rvalid,
    output logic [vecSize*dataSize-1:0]   host_rdata,
    output logic                          host_done,
    output logic                          mem_we,
    output logic [regSize-1:0]            mem_addr,
    output logic [vecSize*dataSize-1:0]   mem_wdata,
    input  logic [vecSize*dataSize-1:0]   mem_rdata
);

    localparam int starveW = $clog2(starveLimit + 1);

    state_t             state;
    state_t             nextState;
    logic [starveW-1:0] starveCnt;
    logic               accept;
    logic               pipeGrant;
    logic               burstWe;
    logic               lastBeat;
    logic               lenZero;
    logic [regSize-1:0] beatAddr;

    assign accept     = (state == IDLE) && host_req;
    assign host_beat  = (state == BURST) && (!pipe_req || (starveCnt == starveW'(starveLimit)));
    assign pipeGrant  = pipe_req && !host_beat;
    assign pipe_stall = pipe_req && host_beat;
    assign host_busy  = (state != IDLE);
    assign host_done  = (state == DONE);

    dmem_burst_counter #(
        .vecSize  (vecSize),
        .regSize  (regSize),
        .maxBurst (maxBurst)
    ) burstCounter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .advance  (host_beat),
        .we       (host_we),
        .base     (host_base),
        .len      (host_len),
        .burstWe  (burstWe),
        .beatAddr (beatAddr),
        .lastBeat (lastBeat),
        .lenZero  (lenZero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (host_req) nextState = lenZero ? DONE : BURST;
            BURST:   if (host_beat && lastBeat) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Counts burst cycles lost to the pipeline; at the limit the host takes the next beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starveCnt <= '0;
        end else if (accept || host_beat) begin
            starveCnt <= '0;
        end else if ((state == BURST) && (starveCnt != starveW'(starveLimit))) begin
            starveCnt <= starveCnt + starveW'(1);
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (host_beat) begin
            mem_we    = burstWe;
            mem_addr  = beatAddr;
            mem_wdata = host_wdata;
        end else if (pipeGrant) begin
            mem_we    = pipe_we;
            mem_addr  = pipe_addr;
            mem_wdata = pipe_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_rvalid <= 1'b0;
            pipe_rdata  <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            pipe_rvalid <= pipeGrant && !pipe_we;
            host_rvalid <= host_beat && !burstWe;
            if (pipeGrant && !pipe_we) pipe_rdata <= mem_rdata;
            if (host_beat && !burstWe) host_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Table-driven bench for dmem_port_arbiter: per-cycle vectors plus a one-deep read-return
// scoreboard, with hand-built sequences for starvation, clamping and reset mid-burst.
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pipeReq, pipeWe, pipeStall, pipeRvalid;
    logic [15:0] pipeAddr;
    logic [31:0] pipeWdata, pipeRdata;
    logic        hostReq, hostWe, hostBusy, hostBeat, hostRvalid, hostDone;
    logic [15:0] hostBase;
    logic [4:0]  hostLen;
    logic [31:0] hostWdata, hostRdata;
    logic        memWe;
    logic [15:0] memAddr;
    logic [31:0] memWdata;
    beat_t       memRdata;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        pReq, pWe;
        logic [15:0] pAddr;
        logic [31:0] pWd;
        logic        hReq, hWe;
        logic [15:0] hBase;
        logic [4:0]  hLen;
        logic [31:0] hWd;
        logic        eWe;
        logic [15:0] eAddr;
        logic [31:0] eWd;
        logic        eBeat, eStall, eBusy, eDone, ePRv, eHRv;
    } vec_t;

    typedef struct {
        string       name;
        logic        pRv, hRv;
        logic [31:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    always #5 clk = ~clk;

    // Memory content is a fixed function of the address so read data is predictable.
    function automatic logic [31:0] memFn(input logic [15:0] a);
        return {a ^ 16'hA5A5, a};
    endfunction

    assign memRdata = memFn(memAddr);

    dmem_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_req    (pipeReq),
        .pipe_we     (pipeWe),
        .pipe_addr   (pipeAddr),
        .pipe_wdata  (pipeWdata),
        .pipe_stall  (pipeStall),
        .pipe_rvalid (pipeRvalid),
        .pipe_rdata  (pipeRdata),
        .host_req    (hostReq),
        .host_we     (hostWe),
        .host_base   (hostBase),
        .host_len    (hostLen),
        .host_wdata  (hostWdata),
        .host_busy   (hostBusy),
        .host_beat   (hostBeat),
        .host_rvalid (hostRvalid),
        .host_rdata  (hostRdata),
        .host_done   (hostDone),
        .mem_we      (memWe),
        .mem_addr    (memAddr),
        .mem_wdata   (memWdata),
        .mem_rdata   (memRdata)
    );

    function automatic vec_t mk(input string name,
                                input logic pReq, input logic pWe, input logic [15:0] pAddr,
                                input logic [31:0] pWd, input logic hReq, input logic hWe,
                                input logic [15:0] hBase, input logic [4:0] hLen, input logic [31:0] hWd,
                                input logic eWe, input logic [15:0] eAddr, input logic [31:0] eWd,
                                input logic eBeat, input logic eStall, input logic eBusy,
                                input logic eDone, input logic ePRv, input logic eHRv);
        vec_t v;
        v.name = name;  v.pReq = pReq;   v.pWe = pWe;     v.pAddr = pAddr; v.pWd = pWd;
        v.hReq = hReq;  v.hWe = hWe;     v.hBase = hBase; v.hLen = hLen;   v.hWd = hWd;
        v.eWe = eWe;    v.eAddr = eAddr; v.eWd = eWd;     v.eBeat = eBeat; v.eStall = eStall;
        v.eBusy = eBusy; v.eDone = eDone; v.ePRv = ePRv;  v.eHRv = eHRv;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".memWe"},      32'(memWe),      32'h0);
        checkOutput({tag, ".memAddr"},    32'(memAddr),    32'h0);
        checkOutput({tag, ".memWdata"},   memWdata,        32'h0);
        checkOutput({tag, ".hostBusy"},   32'(hostBusy),   32'h0);
        checkOutput({tag, ".hostBeat"},   32'(hostBeat),   32'h0);
        checkOutput({tag, ".hostDone"},   32'(hostDone),   32'h0);
        checkOutput({tag, ".pipeStall"},  32'(pipeStall),  32'h0);
        checkOutput({tag, ".pipeRvalid"}, 32'(pipeRvalid), 32'h0);
        checkOutput({tag, ".hostRvalid"}, 32'(hostRvalid), 32'h0);
        checkOutput({tag, ".pipeRdata"},  pipeRdata,       32'h0);
        checkOutput({tag, ".hostRdata"},  hostRdata,       32'h0);
    endtask

    // Drives one cycle of inputs, checks the combinational response and queues the read return.
    task automatic applyStimulus(input vec_t v);
        sb_t s;
        @(negedge clk);
        pipeReq = v.pReq;  pipeWe = v.pWe;  pipeAddr = v.pAddr;  pipeWdata = v.pWd;
        hostReq = v.hReq;  hostWe = v.hWe;  hostBase = v.hBase;  hostLen = v.hLen;
        hostWdata = v.hWd;
        #1;
        checkOutput({v.name, ".memWe"},     32'(memWe),     32'(v.eWe));
        checkOutput({v.name, ".memAddr"},   32'(memAddr),   32'(v.eAddr));
        checkOutput({v.name, ".memWdata"},  memWdata,       v.eWd);
        checkOutput({v.name, ".hostBeat"},  32'(hostBeat),  32'(v.eBeat));
        checkOutput({v.name, ".pipeStall"}, 32'(pipeStall), 32'(v.eStall));
        checkOutput({v.name, ".hostBusy"},  32'(hostBusy),  32'(v.eBusy));
        checkOutput({v.name, ".hostDone"},  32'(hostDone),  32'(v.eDone));
        s.name = v.name;
        s.pRv  = v.ePRv;
        s.hRv  = v.eHRv;
        s.data = memFn(v.eAddr);
        sb.push_back(s);
    endtask

    task automatic retire();
        sb_t s;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard: got empty queue expected one entry");
        end else begin
            s = sb.pop_front();
            checkOutput({s.name, ".pipeRvalid"}, 32'(pipeRvalid), 32'(s.pRv));
            checkOutput({s.name, ".hostRvalid"}, 32'(hostRvalid), 32'(s.hRv));
            if (s.pRv) checkOutput({s.name, ".pipeRdata"}, pipeRdata, s.data);
            if (s.hRv) checkOutput({s.name, ".hostRdata"}, hostRdata, s.data);
        end
    endtask

    task automatic runVecs();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            retire();
        end
        vecs.delete();
    endtask

    initial begin
        pipeReq = 0; pipeWe = 0; pipeAddr = '0; pipeWdata = '0;
        hostReq = 0; hostWe = 0; hostBase = '0; hostLen = '0; hostWdata = '0;
        #1 reset = 1'b1;
        #3 checkAllZero("reset");
        @(negedge clk) reset = 1'b0;

        //                name          pReq pWe pAddr     pWd           hReq hWe hBase     hLen  hWd           eWe eAddr     eWd           bt st by dn pRv hRv
        vecs.push_back(mk("pipeRd",     1, 0, 16'h0010, 32'h11223344, 0, 0, 16'h0000, 5'd0, 32'h0,        0, 16'h0010, 32'h11223344, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("pipeWr",     1, 1, 16'h0020, 32'hDEADBEEF, 0, 0, 16'h0000, 5'd0, 32'h0,        1, 16'h0020, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("idle0",      0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'h0,        0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("wrAccept",   0, 0, 16'h0000, 32'h0,        1, 1, 16'h0100, 5'd3, 32'hAAAA0000, 0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("wrBeat0",    0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'hAAAA0001, 1, 16'h0100, 32'hAAAA0001, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("wrBeat1",    0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'hAAAA0002, 1, 16'h0104, 32'hAAAA0002, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("wrBeat2",    0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'hAAAA0003, 1, 16'h0108, 32'hAAAA0003, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("wrDone",     0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'h0,        0, 16'h0000, 32'h0,        0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("wrIdle",     0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'h0,        0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("simulAcc",   1, 0, 16'h0040, 32'h0,        1, 0, 16'h0200, 5'd2, 32'h0,        0, 16'h0040, 32'h0,        0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("rdBeat0Ign", 0, 0, 16'h0000, 32'h0,        1, 1, 16'h0300, 5'd5, 32'h0,        0, 16'h0200, 32'h0,        1, 0, 1, 0, 0, 1));
        vecs.push_back(mk("rdBeat1",    0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'h0,        0, 16'h0204, 32'h0,        1, 0, 1, 0, 0, 1));
        vecs.push_back(mk("rdDone",     0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'h0,        0, 16'h0000, 32'h0,        0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("rdIdle",     0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'h0,        0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("len0Acc",    0, 0, 16'h0000, 32'h0,        1, 1, 16'h0500, 5'd0, 32'h12345678, 0, 16'h0000, 32'h0,       0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("len0Done",   0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'h12345678, 0, 16'h0000, 32'h0,       0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("len0Idle",   0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'h0,        0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("wrapAcc",    0, 0, 16'h0000, 32'h0,        1, 1, 16'hFFFC, 5'd2, 32'h0,        0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("wrapBeat0",  0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'h01010101, 1, 16'hFFFC, 32'h01010101, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("wrapBeat1",  0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'h02020202, 1, 16'h0000, 32'h02020202, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("wrapDone",   0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'h0,        0, 16'h0000, 32'h0,        0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("wrapIdle",   0, 0, 16'h0000, 32'h0,        0, 0, 16'h0000, 5'd0, 32'h0,        0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0));
        runVecs();

        // Pipeline hogs the port: the host is forced a beat after every four lost cycles.
        vecs.push_back(mk("stvAcc", 1, 0, 16'h0030, 32'h0, 1, 1, 16'h0800, 5'd2, 32'h0, 0, 16'h0030, 32'h0, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9)
                vecs.push_back(mk($sformatf("stvBeat%0d", k), 1, 0, 16'h0030, 32'h0, 0, 0, 16'h0, 5'd0,
                                  32'h55000000 + k, 1, (k == 4) ? 16'h0800 : 16'h0804, 32'h55000000 + k,
                                  1, 1, 1, 0, 0, 0));
            else
                vecs.push_back(mk($sformatf("stvPipe%0d", k), 1, 0, 16'h0030, 32'h0, 0, 0, 16'h0, 5'd0,
                                  32'h55000000 + k, 0, 16'h0030, 32'h0, 0, 0, 1, 0, 1, 0));
        end
        vecs.push_back(mk("stvDone", 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 5'd0, 32'h0, 0, 16'h0, 32'h0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("stvIdle", 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 5'd0, 32'h0, 0, 16'h0, 32'h0, 0, 0, 0, 0, 0, 0));
        runVecs();

        // Oversized length is clamped to sixteen beats.
        vecs.push_back(mk("clampAcc", 0, 0, 16'h0, 32'h0, 1, 1, 16'h1000, 5'd31, 32'h0, 0, 16'h0, 32'h0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 16; k++)
            vecs.push_back(mk($sformatf("clampBeat%0d", k), 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 5'd0,
                              32'hC0DE0000 + k, 1, 16'h1000 + 16'(4 * k), 32'hC0DE0000 + k, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("clampDone", 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 5'd0, 32'h0, 0, 16'h0, 32'h0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("clampIdle", 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 5'd0, 32'h0, 0, 16'h0, 32'h0, 0, 0, 0, 0, 0, 0));
        runVecs();

        // Read burst of five, reset lands during beat 2.
        vecs.push_back(mk("rstAcc",   0, 0, 16'h0, 32'h0, 1, 0, 16'h2000, 5'd5, 32'h0, 0, 16'h0,    32'h0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rstBeat0", 0, 0, 16'h0, 32'h0, 0, 0, 16'h0,    5'd0, 32'h0, 0, 16'h2000, 32'h0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk("rstBeat1", 0, 0, 16'h0, 32'h0, 0, 0, 16'h0,    5'd0, 32'h0, 0, 16'h2004, 32'h0, 1, 0, 1, 0, 0, 1));
        runVecs();
        applyStimulus(mk("rstBeat2", 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 5'd0, 32'h0, 0, 16'h2008, 32'h0, 1, 0, 1, 0, 0, 1));
        sb.delete();
        #1 reset = 1'b1;
        #1 checkAllZero("midBurstReset");
        @(posedge clk);
        #1 checkAllZero("heldReset");
        @(negedge clk) reset = 1'b0;
        vecs.push_back(mk("postRstIdle", 0, 0, 16'h0, 32'h0, 0, 0, 16'h0,    5'd0, 32'h0, 0, 16'h0,    32'h0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("newAcc",      0, 0, 16'h0, 32'h0, 1, 0, 16'h3000, 5'd1, 32'h0, 0, 16'h0,    32'h0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("newBeat0",    0, 0, 16'h0, 32'h0, 0, 0, 16'h0,    5'd0, 32'h0, 0, 16'h3000, 32'h0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk("newDone",     0, 0, 16'h0, 32'h0, 0, 0, 16'h0,    5'd0, 32'h0, 0, 16'h0,    32'h0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("newIdle",     0, 0, 16'h0, 32'h0, 0, 0, 16'h0,    5'd0, 32'h0, 0, 16'h0,    32'h0, 0, 0, 0, 0, 0, 0));
        runVecs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
